// File: rtl/add_core_pkg.sv
// Shared constants for the add_core adder: lookahead group width and the
// parameter legality check used at elaboration.
package add_core_pkg;

  localparam int GRP_W = 4;

  function automatic bit width_ok(input int w);
    return (w >= GRP_W) && ((w % GRP_W) == 0);
  endfunction

endpackage

// File: rtl/add_core_if.sv
// Operand/result bundle for add_core: operands and qualifier in, combinational
// and registered sums plus valid flag out.
interface add_core_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic [WIDTH:0]   Sum;
  logic [WIDTH:0]   sum_q;
  logic             out_valid;

  modport master (
    output A, B, in_valid,
    input  Sum, sum_q, out_valid
  );

  modport slave (
    input  A, B, in_valid,
    output Sum, sum_q, out_valid
  );

endinterface

// File: rtl/add_core_cla4.sv
// 4-bit carry-lookahead group: flattened internal carries plus group
// generate/propagate for a possible second lookahead level.
module cla4
  import add_core_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             cout,
  output logic             gg,
  output logic             gp
);

  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] p;
  logic [GRP_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded to a two-level sum of products of g, p and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[GRP_W-1:0];
  assign cout = c[4];
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign gp   = &p;

endmodule

// File: rtl/add_core.sv
// Unsigned WIDTH-bit adder with carry-out: rippled chain of 4-bit CLA groups,
// combinational result plus a one-cycle registered copy with valid flag.
module add_core
  import add_core_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  add_core_if.slave   bus
);

  localparam int NGRP = WIDTH / GRP_W;

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("add_core: WIDTH must be a multiple of 4 and at least 4");
  end

  logic [NGRP:0]    carry;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   comb_sum;
  // Group G/P are not consumed yet; kept for a future two-level lookahead.
  logic [NGRP-1:0]  gg_unused;
  logic [NGRP-1:0]  gp_unused;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    cla4 u_cla4 (
      .a    (bus.A[gi*GRP_W +: GRP_W]),
      .b    (bus.B[gi*GRP_W +: GRP_W]),
      .cin  (carry[gi]),
      .s    (sum_bits[gi*GRP_W +: GRP_W]),
      .cout (carry[gi+1]),
      .gg   (gg_unused[gi]),
      .gp   (gp_unused[gi])
    );
  end

  assign comb_sum = {carry[NGRP], sum_bits};
  assign bus.Sum  = comb_sum;

  logic [WIDTH:0] sum_d;
  logic [WIDTH:0] sum_q;
  logic           out_valid_d;
  logic           out_valid_q;

  // Idle cycles hold the last result but drop the valid flag.
  always_comb begin
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d       = comb_sum;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum_q     = sum_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_add_core.sv
// Directed self-checking bench for add_core (WIDTH=16): combinational sum,
// registered path, asynchronous reset and per-group carry corners.
module tb_add_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  add_core_if #(.WIDTH(16)) bus ();

  add_core #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] va [6];
  logic [15:0] vb [6];
  logic [16:0] vs [6];
  logic [15:0] sa;
  logic [15:0] sb;
  logic [16:0] se;

  initial begin
    checks = 0;
    errors = 0;
    va = '{16'h1234, 16'h8000, 16'hABCD, 16'h7FFF, 16'h0F0F, 16'hFFFF};
    vb = '{16'h4321, 16'h8000, 16'h1234, 16'h0001, 16'hF0F0, 16'h0000};
    vs = '{17'd21845, 17'h10000, 17'h0BE01, 17'h08000, 17'h0FFFF, 17'h0FFFF};

    // Reset state
    rst_n = 1'b0;
    bus.A = 16'h0003;
    bus.B = 16'h0004;
    bus.in_valid = 1'b1;
    #12;
    check("rst_sum_q", bus.sum_q, 17'd0);
    check("rst_out_valid", {16'd0, bus.out_valid}, 17'd0);
    check("rst_comb_sum", bus.Sum, 17'd7);

    @(negedge clk);
    rst_n = 1'b1;
    // 1. zero operands through both paths
    bus.A = 16'h0000;
    bus.B = 16'h0000;
    bus.in_valid = 1'b1;
    #1 check("zero_sum", bus.Sum, 17'd0);
    @(posedge clk);
    #1;
    check("zero_sum_q", bus.sum_q, 17'd0);
    check("zero_out_valid", {16'd0, bus.out_valid}, 17'd1);

    // 2. carry-out and full ripple
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = 16'hFFFF;
    bus.B = 16'hFFFF;
    #1 check("max_sum", bus.Sum, 17'd131070);
    bus.A = 16'hFFFF;
    bus.B = 16'h0001;
    #1 check("ripple_sum", bus.Sum, 17'h10000);

    // 3. vector stream: new A/B each rising edge, sample at falling edge
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bus.A = va[i];
      bus.B = vb[i];
      bus.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("stream_sum_%0d", i), bus.Sum, vs[i]);
      if (i > 0) begin
        check($sformatf("stream_sum_q_%0d", i), bus.sum_q, vs[i-1]);
        check($sformatf("stream_valid_%0d", i), {16'd0, bus.out_valid}, 17'd1);
      end
    end

    // 4. registered path: in_valid 1,1,0,1 with sums 5,9,12(ignored),7
    @(negedge clk);
    bus.A = 16'd2; bus.B = 16'd3; bus.in_valid = 1'b1;
    @(negedge clk);
    check("reg_q_0", bus.sum_q, 17'd5);
    check("reg_v_0", {16'd0, bus.out_valid}, 17'd1);
    bus.A = 16'd4; bus.B = 16'd5; bus.in_valid = 1'b1;
    @(negedge clk);
    check("reg_q_1", bus.sum_q, 17'd9);
    check("reg_v_1", {16'd0, bus.out_valid}, 17'd1);
    bus.A = 16'd6; bus.B = 16'd6; bus.in_valid = 1'b0;
    @(negedge clk);
    check("reg_q_2_hold", bus.sum_q, 17'd9);
    check("reg_v_2", {16'd0, bus.out_valid}, 17'd0);
    bus.A = 16'd3; bus.B = 16'd4; bus.in_valid = 1'b1;
    @(negedge clk);
    check("reg_q_3", bus.sum_q, 17'd7);
    check("reg_v_3", {16'd0, bus.out_valid}, 17'd1);

    // 5. asynchronous reset between edges while out_valid=1
    bus.A = 16'h0100; bus.B = 16'h0022; bus.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sum_q", bus.sum_q, 17'd0);
    check("async_rst_valid", {16'd0, bus.out_valid}, 17'd0);
    check("async_rst_comb", bus.Sum, 17'h00122);
    @(posedge clk);
    #1 check("held_rst_valid", {16'd0, bus.out_valid}, 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 check("post_rst_idle_valid", {16'd0, bus.out_valid}, 17'd0);
    check("post_rst_idle_sum_q", bus.sum_q, 17'd0);
    @(negedge clk);
    bus.A = 16'd1; bus.B = 16'd1; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 check("recover_sum_q", bus.sum_q, 17'd2);
    check("recover_valid", {16'd0, bus.out_valid}, 17'd1);

    // 6. per-group carry corners and exhaustive nibble sweep
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = 16'h000F; bus.B = 16'h0001;
    #1 check("grp0_carry", bus.Sum, 17'h00010);
    bus.A = 16'h00F0; bus.B = 16'h0010;
    #1 check("grp1_carry", bus.Sum, 17'h00100);
    for (int g = 0; g < 4; g++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          sa = 16'(a) << (4 * g);
          sb = 16'(b) << (4 * g);
          se = 17'(a + b) << (4 * g);
          bus.A = sa;
          bus.B = sb;
          #1 check($sformatf("sweep_g%0d_%0h_%0h", g, a, b), bus.Sum, se);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
